// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage iterative divider: state encoding,
// word-bus helpers and the decoder's DIV/DIVU opcode constants.
package div_seq_pkg;

    typedef logic [31:0] WORD_BUS;

    localparam WORD_BUS ZERO_WORD = '0;
    localparam logic    ENABLE    = 1'b1;
    localparam logic    DISABLE   = 1'b0;

    // Decoder drives start/signed_op from these
    localparam logic [3:0] EX_ARITH_DIV  = 4'hA;
    localparam logic [3:0] EX_ARITH_DIVU = 4'hB;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider, purely combinational:
// shifts {rem, quo} left by one and conditionally subtracts the divisor.
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] remShift;

    always_comb begin
        // Extra top bit keeps the shifted remainder exact before the compare
        remShift = {rem, quo[WIDTH-1]};
        quoNext  = {quo[WIDTH-2:0], 1'b0};
        remNext  = remShift[WIDTH-1:0];
        if (remShift >= {1'b0, divisor}) begin
            remNext    = WIDTH'(remShift - {1'b0, divisor});
            quoNext[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage; stalls the pipeline and
// issues one HILO write. Optional macro DIV_EARLY_OUT_EN skips the loop when |divisor| > |dividend|.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stall_req,
    output logic             o_we,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             div_zero,
    output logic             busy
);

    divState_t        state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic             signQ, signR;
    logic [WIDTH-1:0] remQ, quoQ, divMag;
    logic [WIDTH-1:0] remStep, quoStep;
    logic [WIDTH-1:0] dvdAbs, dvsAbs;
    logic             oWeQ, divZeroQ;
    logic [WIDTH-1:0] oHiQ, oLoQ;
    logic             startGo, lastStep, earlyOut;

    div_step #(.WIDTH(WIDTH)) uStep (
        .rem     (remQ),
        .quo     (quoQ),
        .divisor (divMag),
        .remNext (remStep),
        .quoNext (quoStep)
    );

    always_comb begin
        dvdAbs   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvsAbs   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        startGo  = start & ~annul;
        lastStep = (cnt == CNT_W'(WIDTH-1));
`ifdef DIV_EARLY_OUT_EN
        earlyOut = (dvsAbs > dvdAbs);
`else
        earlyOut = 1'b0;
`endif
        stateNext = state;
        stall_req = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (startGo) begin
                    stall_req = 1'b1;
                    stateNext = (divisor == '0 || earlyOut) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stall_req = ~annul;
                if (lastStep) stateNext = DIV_DONE;
            end
            DIV_DONE: stateNext = DIV_IDLE;
            default:  stateNext = DIV_IDLE;
        endcase
        if (annul) stateNext = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= stateNext;
    end

    // Result registers are loaded on the edge entering DONE and cleared on every other edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            remQ     <= '0;
            quoQ     <= '0;
            divMag   <= '0;
            oWeQ     <= DISABLE;
            divZeroQ <= 1'b0;
            oHiQ     <= '0;
            oLoQ     <= '0;
        end else begin
            oWeQ     <= DISABLE;
            divZeroQ <= 1'b0;
            oHiQ     <= '0;
            oLoQ     <= '0;
            case (state)
                DIV_IDLE: begin
                    if (startGo) begin
                        signQ  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        signR  <= signed_op & dividend[WIDTH-1];
                        quoQ   <= dvdAbs;
                        divMag <= dvsAbs;
                        remQ   <= '0;
                        cnt    <= '0;
                        if (divisor == '0) begin
                            oWeQ     <= ENABLE;
                            divZeroQ <= 1'b1;
                        end else if (earlyOut) begin
                            oWeQ <= ENABLE;
                            oHiQ <= (signed_op && dividend[WIDTH-1]) ? -dvdAbs : dvdAbs;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        remQ <= remStep;
                        quoQ <= quoStep;
                        cnt  <= cnt + 1'b1;
                        if (lastStep) begin
                            oWeQ <= ENABLE;
                            oLoQ <= signQ ? -quoStep : quoStep;
                            oHiQ <= signR ? -remStep : remStep;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_we     = oWeQ & ~annul;
    assign div_zero = divZeroQ & ~annul;
    assign o_hi     = oHiQ;
    assign o_lo     = oLoQ;
    assign busy     = (state != DIV_IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected HILO writes are queued at issue and
// checked by an independent monitor against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst, start, signed_op, annul;
    logic [31:0] dividend, divisor;
    logic        stall_req, o_we, div_zero, busy;
    logic [31:0] o_hi, o_lo;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .annul     (annul),
        .stall_req (stall_req),
        .o_we      (o_we),
        .o_hi      (o_hi),
        .o_lo      (o_lo),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, truncating division as MIPS DIV/DIVU define it
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] hi, output logic [31:0] lo,
                                   output logic dz, output int lat);
        longint sa, sbv, q, r, ma, mb;
        hi = '0; lo = '0; dz = 1'b0; lat = 1;
        if (b == 32'd0) begin
            dz = 1'b1;
            return;
        end
        sa  = s ? longint'($signed(a)) : longint'(a);
        sbv = s ? longint'($signed(b)) : longint'(b);
        q = sa / sbv;
        r = sa % sbv;
        lo = q[31:0];
        hi = r[31:0];
        ma = (sa < 0) ? -sa : sa;
        mb = (sbv < 0) ? -sbv : sbv;
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) lat = 1;
`else
        if (mb > ma + 64'sd1 << 40) lat = 33;
`endif
    endfunction

    // Monitor: every HILO write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (o_we) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpectedWrite @cycle %0d: o_we=1, required 0", cyc);
            end else begin
                monE = expQ.pop_front();
                chk("hi", o_hi, monE.hi);
                chk("lo", o_lo, monE.lo);
                chk("divZero", {31'b0, div_zero}, {31'b0, monE.dz});
                chk("writeCycle", cyc, monE.due);
            end
        end else if (expQ.size() != 0 && cyc > expQ[0].due) begin
            monE = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missingWrite: no o_we by cycle %0d, required at %0d", cyc, monE.due);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit expectWrite, output int t, output int lat);
        exp_t e;
        refDiv(a, b, s, e.hi, e.lo, e.dz, lat);
        @(posedge clk); #1;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        t = cyc;
        e.due = t + lat;
        if (expectWrite) expQ.push_back(e);
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t, lat;
        issue(a, b, s, 1'b1, t, lat);
        @(negedge clk); chk("stallStart", {31'b0, stall_req}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk); chk("stallBusy", {31'b0, stall_req}, 32'd1);
        end
        @(negedge clk);
        chk("stallDone", {31'b0, stall_req}, 32'd0);
        chk("busyDone", {31'b0, busy}, 32'd1);
        @(negedge clk); chk("busyAfter", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, lat;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstStall", {31'b0, stall_req}, 32'd0);
        chk("rstWe", {31'b0, o_we}, 32'd0);
        chk("rstHi", o_hi, 32'd0);
        chk("rstLo", o_lo, 32'd0);
        chk("rstDz", {31'b0, div_zero}, 32'd0);
        chk("rstBusy", {31'b0, busy}, 32'd0);

        runOp(32'd100, 32'd7, 1'b0);
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        runOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runOp(32'hFFFF_FFFF, 32'd1, 1'b0);
        runOp(32'd5, 32'd0, 1'b0);
        runOp(32'd3, 32'd10, 1'b0);
        runOp(32'hFFFF_FFFD, 32'd10, 1'b1);

        // annul at BUSY cycle 10
        issue(32'd100, 32'd7, 1'b0, 1'b0, t, lat);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk); chk("annulStall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1 annul = 1'b0;
        @(negedge clk); chk("annulBusy", {31'b0, busy}, 32'd0);
        runOp(32'd9, 32'd3, 1'b0);

        // annul with start in IDLE
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk); chk("annulStartStall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1 start = 1'b0; annul = 1'b0;
        @(negedge clk); chk("annulStartBusy", {31'b0, busy}, 32'd0);

        // reset at BUSY cycle 20
        issue(32'd1000, 32'd3, 1'b0, 1'b0, t, lat);
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midRstWe", {31'b0, o_we}, 32'd0);
        chk("midRstHi", o_hi, 32'd0);
        chk("midRstLo", o_lo, 32'd0);
        chk("midRstDz", {31'b0, div_zero}, 32'd0);
        chk("midRstStall", {31'b0, stall_req}, 32'd0);
        chk("midRstBusy", {31'b0, busy}, 32'd0);

        // annul in the DONE cycle suppresses the write
        issue(32'd100, 32'd7, 1'b0, 1'b0, t, lat);
        @(posedge clk); #1 start = 1'b0;
        repeat (lat - 1) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("doneAnnulWe", {31'b0, o_we}, 32'd0);
        chk("doneAnnulDz", {31'b0, div_zero}, 32'd0);
        chk("doneAnnulStall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1 annul = 1'b0;
        @(negedge clk); chk("doneAnnulBusy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 60)); end
                4:       b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            runOp(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
